// File: rtl/apb_pkg.sv
// Shared definitions for the APB completer register file.
// Optional feature macro used by the top level: APB_SLVERR_EN.
package apb_pkg;

  localparam int APB_DATA_W   = 32;
  localparam int APB_WORD_LSB = 2;
  localparam int WAIT_CNT_W   = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state counter: loads a start value, counts down to zero, flags zero.
module apb_wait_counter
  import apb_pkg::*;
#(
  parameter int W = WAIT_CNT_W
) (
  input  logic         clk,
  input  logic         i_srst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (!i_srst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with NUM_REGS 32-bit registers; the top index is a read-only
// count of completed transfers. Wait states are programmable.
// Macro APB_SLVERR_EN: when defined, bad accesses report Pslverr.
module apb_slave_regfile
  import apb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] RESET_VAL   = 32'h0
) (
  input  logic                  Hclk,
  input  logic                  Hrstn,
  input  logic                  Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [31:0]           Paddr,
  input  logic [APB_DATA_W-1:0] Pwdata,
  output logic [APB_DATA_W-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr,
  output logic [APB_DATA_W-1:0] reg0_out
);

  localparam int IDX_W   = $clog2(NUM_REGS);
  localparam int RW_REGS = NUM_REGS - 1;
  localparam logic [IDX_W-1:0]      CNT_IDX   = IDX_W'(NUM_REGS - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

  apb_state_e r_state;
  apb_state_e w_state_next;

  logic                  r_write;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_bad;
  logic [APB_DATA_W-1:0] r_regs [RW_REGS];
  logic [APB_DATA_W-1:0] r_xfer_cnt;

  logic                  w_addr_hit;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_bad;
  logic                  w_setup;
  logic                  w_active;
  logic                  w_complete;
  logic                  w_cnt_zero;
  logic [WAIT_CNT_W-1:0] w_cnt;
  logic [APB_DATA_W-1:0] w_rd_word;

  // Base is aligned to the window size, so a hit is an upper-bit match.
  assign w_addr_hit = (Paddr[31:IDX_W+APB_WORD_LSB] == BASE_ADDR[31:IDX_W+APB_WORD_LSB])
                      && (Paddr[APB_WORD_LSB-1:0] == '0);
  assign w_idx      = Paddr[APB_WORD_LSB +: IDX_W];
  assign w_bad      = !w_addr_hit || (Pwrite && (w_idx == CNT_IDX));
  assign w_active   = Pselx && Penable;
  assign w_setup    = (r_state == ST_IDLE) && Pselx && !Penable;

  apb_wait_counter #(
    .W (WAIT_CNT_W)
  ) u_wait_counter (
    .clk        (Hclk),
    .i_srst_n   (Hrstn),
    .i_load     (w_setup),
    .i_load_val (WAIT_LOAD),
    .i_dec      ((r_state == ST_ACCESS) && w_active),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge Hclk) begin
    if (!Hrstn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: leave ACCESS on completion or when the master aborts.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_setup) w_state_next = ST_ACCESS;
      ST_ACCESS: if (!w_active || w_cnt_zero) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // Output logic: completion strobe.
  always_comb begin
    w_complete = (r_state == ST_ACCESS) && w_cnt_zero && w_active;
    Pready     = w_complete;
  end

  // Capture the transfer attributes in the setup phase; later bus changes are ignored.
  always_ff @(posedge Hclk) begin
    if (!Hrstn) begin
      r_write <= 1'b0;
      r_idx   <= '0;
      r_bad   <= 1'b0;
    end else if (w_setup) begin
      r_write <= Pwrite;
      r_idx   <= w_idx;
      r_bad   <= w_bad;
    end
  end

  // Read/write registers; write data is sampled on the completion edge.
  always_ff @(posedge Hclk) begin
    for (int i = 0; i < RW_REGS; i++) begin
      if (!Hrstn) begin
        r_regs[i] <= RESET_VAL;
      end else if (w_complete && r_write && !r_bad && (r_idx == IDX_W'(i))) begin
        r_regs[i] <= Pwdata;
      end
    end
  end

  // Completed-transfer counter, errored completions included; wraps naturally.
  always_ff @(posedge Hclk) begin
    if (!Hrstn) begin
      r_xfer_cnt <= '0;
    end else if (w_complete) begin
      r_xfer_cnt <= r_xfer_cnt + 32'd1;
    end
  end

  // Read mux over the register array plus the transfer counter.
  always_comb begin
    w_rd_word = r_xfer_cnt;
    for (int i = 0; i < RW_REGS; i++) begin
      if (r_idx == IDX_W'(i)) w_rd_word = r_regs[i];
    end
  end

  assign Prdata   = (w_complete && !r_write && !r_bad) ? w_rd_word : '0;
  assign reg0_out = r_regs[0];

`ifdef APB_SLVERR_EN
  assign Pslverr = r_bad && w_complete;
`else
  assign Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized scoreboard bench for apb_slave_regfile.
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h0000_0200;
  localparam int          NREG = 8;
  localparam int          WAIT = 2;
  localparam logic [31:0] RSTV = 32'hA5A5_0000;
`ifdef APB_SLVERR_EN
  localparam bit SLV_EN = 1'b1;
`else
  localparam bit SLV_EN = 1'b0;
`endif

  logic        Hclk = 1'b0;
  logic        Hrstn = 1'b0;
  logic        Pselx = 1'b0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;
  logic [31:0] reg0_out;

  apb_slave_regfile #(
    .BASE_ADDR   (BASE),
    .NUM_REGS    (NREG),
    .WAIT_CYCLES (WAIT),
    .RESET_VAL   (RSTV)
  ) dut (
    .Hclk     (Hclk),
    .Hrstn    (Hrstn),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata),
    .Prdata   (Prdata),
    .Pready   (Pready),
    .Pslverr  (Pslverr),
    .reg0_out (reg0_out)
  );

  always #5 Hclk = ~Hclk;

  int cyc = 0;
  always @(posedge Hclk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        slverr;
    int          cycle;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;

  // Reference model: architectural register contents and transfer count.
  logic [31:0] m_regs [NREG];
  logic [31:0] m_cnt;

  function automatic bit m_hit(input logic [31:0] a);
    longint unsigned la = longint'(a);
    longint unsigned lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * NREG) && ((la % 4) == 0);
  endfunction

  function automatic int m_index(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG - 1; i++) m_regs[i] = RSTV;
    m_regs[NREG-1] = '0;
    m_cnt = '0;
  endtask

  // Monitor: pops and compares on every completion; otherwise outputs must be 0.
  always @(negedge Hclk) begin
    exp_t e;
    if (Hrstn) begin
      if (Pready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pready: cycle %0d Prdata=%h Pslverr=%b, no transfer outstanding",
                   cyc, Prdata, Pslverr);
        end else begin
          e = exp_q.pop_front();
          txn_no++;
          $display("txn %0d %s addr=%h rdata=%h slverr=%b cycle=%0d",
                   txn_no, e.wr ? "WR" : "RD", e.addr, Prdata, Pslverr, cyc);
          if (Prdata !== e.rdata || Pslverr !== e.slverr || cyc != e.cycle) begin
            errors++;
            $display("FAIL completion addr=%h: got rdata=%h slverr=%b cycle=%0d, expected rdata=%h slverr=%b cycle=%0d",
                     e.addr, Prdata, Pslverr, cyc, e.rdata, e.slverr, e.cycle);
          end
        end
      end else begin
        checks++;
        if (Prdata !== 32'h0 || Pslverr !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: cycle %0d Prdata=%h Pslverr=%b, expected 0/0", cyc, Prdata, Pslverr);
        end
      end
    end
  end

  task automatic check_reg0(input string tag);
    checks++;
    if (reg0_out !== m_regs[0]) begin
      errors++;
      $display("FAIL reg0_out %s: got %h expected %h", tag, reg0_out, m_regs[0]);
    end
  endtask

  // All tasks start at #1 after a rising edge and end there too.
  task automatic idle(input int n);
    Pselx = 1'b0;
    Penable = 1'b0;
    repeat (n) begin
      @(posedge Hclk);
      #1;
    end
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit scramble);
    exp_t e;
    bit   bad;
    int   idx;
    bit   done = 1'b0;
    idx = m_hit(a) ? m_index(a) : 0;
    bad = !m_hit(a) || (wr && idx == NREG - 1);
    e.wr     = wr;
    e.addr   = a;
    e.rdata  = (!wr && !bad) ? ((idx == NREG - 1) ? m_cnt : m_regs[idx]) : 32'h0;
    e.slverr = SLV_EN && bad;
    e.cycle  = cyc + 1 + WAIT;
    exp_q.push_back(e);
    if (wr && !bad) m_regs[idx] = d;
    m_cnt = m_cnt + 32'd1;

    Pselx = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = d;
    @(posedge Hclk);
    #1;
    Penable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Hclk);
      if (Pready) begin
        done = 1'b1;
        break;
      end
      if (scramble) begin
        Paddr  = $urandom;
        Pwrite = ~wr;
      end
    end
    @(posedge Hclk);
    #1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout addr=%h: Pready=0 after 40 cycles, expected completion", a);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    check_reg0("after_xfer");
  endtask

  // Master drops the access phase while wait states are still pending.
  task automatic abort_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = a; Pwdata = d;
    @(posedge Hclk);
    #1;
    Penable = 1'b1;
    @(posedge Hclk);
    #1;
    Pselx = 1'b0;
    Penable = 1'b0;
    @(posedge Hclk);
    #1;
    check_reg0("after_abort");
  endtask

  // Reset asserted while a transfer sits in its wait states.
  task automatic reset_mid(input logic [31:0] a, input logic [31:0] d);
    Pselx = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = a; Pwdata = d;
    @(posedge Hclk);
    #1;
    Penable = 1'b1;
    @(posedge Hclk);
    #1;
    Hrstn = 1'b0;
    @(posedge Hclk);
    #1;
    Pselx = 1'b0;
    Penable = 1'b0;
    @(posedge Hclk);
    #1;
    Hrstn = 1'b1;
    model_reset();
    check_reg0("after_reset_mid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    model_reset();
    Hrstn = 1'b0;
    repeat (3) @(posedge Hclk);
    #1;
    Hrstn = 1'b1;

    checks++;
    if (Pready !== 1'b0 || Prdata !== 32'h0 || Pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: Pready=%b Prdata=%h Pslverr=%b expected 0/0/0", Pready, Prdata, Pslverr);
    end
    check_reg0("reset");

    // Basic write/read and readback of every register after reset.
    xfer(1'b1, BASE, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    xfer(1'b0, BASE, 32'h0, 1'b0);
    for (int i = 0; i < NREG; i++) xfer(1'b0, BASE + 32'(4 * i), 32'h0, 1'b0);

    // Error cases: write to the counter, outside the window, misaligned.
    xfer(1'b1, BASE + 32'h1C, 32'h1234_5678, 1'b0);
    xfer(1'b0, BASE + 32'h40, 32'h0, 1'b0);
    xfer(1'b0, BASE - 32'h4, 32'h0, 1'b0);
    xfer(1'b1, BASE + 32'h6, 32'hCAFE_F00D, 1'b0);
    xfer(1'b0, BASE + 32'h4, 32'h0, 1'b0);
    xfer(1'b0, BASE + 32'h1C, 32'h0, 1'b0);

    // Abort during wait states; target must stay unchanged.
    abort_xfer(1'b1, BASE + 32'h4, 32'h5555_5555);
    xfer(1'b0, BASE + 32'h4, 32'h0, 1'b0);

    // Reset mid-access, then back-to-back write/read.
    xfer(1'b1, BASE + 32'h8, 32'h1111_2222, 1'b0);
    reset_mid(BASE + 32'h8, 32'h9999_9999);
    xfer(1'b0, BASE + 32'h8, 32'h0, 1'b0);
    xfer(1'b1, BASE + 32'h8, 32'h3333_4444, 1'b0);
    xfer(1'b0, BASE + 32'h8, 32'h0, 1'b0);
    xfer(1'b0, BASE + 32'h1C, 32'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 120; n++) begin
      r = int'($urandom_range(0, 11));
      if (r == 0) begin
        abort_xfer(1'($urandom), BASE + 32'(4 * $urandom_range(0, NREG - 1)), $urandom);
      end else begin
        if (r == 1)      a = BASE + 32'h20 + 32'(4 * $urandom_range(0, 63));
        else if (r == 2) a = BASE - 32'(4 * $urandom_range(1, 16));
        else if (r == 3) a = BASE + 32'(4 * $urandom_range(0, NREG - 1)) + 32'($urandom_range(1, 3));
        else             a = BASE + 32'(4 * $urandom_range(0, NREG - 1));
        xfer(1'($urandom), a, $urandom, 1'($urandom));
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d transfers outstanding, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
